// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
// Entry layout is {pc, instr}; legality covers word alignment and the 64-word ROM window.
package fetch_pkg;

    localparam int FETCH_PC_W    = 64;
    localparam int FETCH_INSTR_W = 32;
    localparam int PC_STEP       = 4;
    localparam int ROM_WORDS     = 64;
    localparam int ROM_AW        = $clog2(ROM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Any bit above the ROM byte window set means the address would wrap the ROM.
    function automatic logic pc_legal(input logic [FETCH_PC_W-1:0] pc);
        return (pc[1:0] == 2'b00) && (pc[FETCH_PC_W-1:ROM_AW+2] == '0);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit boundary: ROM address/data, redirect input, decode-side valid/ready stream.
// master is the fetch unit side, slave is the core/ROM side.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int N       = 64,
    parameter int INSTR_W = 32
);
    logic                en;
    logic [ROM_AW-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_q;
    logic                redirect_valid;
    logic [N-1:0]        redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [N-1:0]        out_pc;
    logic                fault;

    modport master (
        input  en, imem_q, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, fault
    );

    modport slave (
        output en, imem_q, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, fault
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr}; head is registered, held at its last value when empty.
// Latency: push visible at head next cycle; flush beats push/pop; push while full only with pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  fetch_entry_t               i_dat,
    output fetch_entry_t               o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    fetch_entry_t   r_hold;
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? r_hold : r_mem[r_rd];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_hold  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Track whatever is on the head so an emptied queue keeps presenting it.
            if (!o_empty) begin
                r_hold <= r_mem[r_rd];
            end
            if (i_flush) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
            end else begin
                if (w_do_push) begin
                    r_mem[r_wr] <= i_dat;
                    r_wr        <= r_wr + AW'(1);
                end
                if (w_do_pop) begin
                    r_rd <= r_rd + AW'(1);
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch controller: owns the PC, drives the ROM word address, queues {pc, instr} for decode.
// Latency: ROM read to head valid is 1 cycle; PC holds when the queue is full and not draining.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               N        = FETCH_PC_W,
    parameter int               INSTR_W  = FETCH_INSTR_W,
    parameter int               DEPTH    = 2,
    parameter logic [N-1:0]     RESET_PC = '0
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     fif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    fetch_state_e   r_state;
    fetch_state_e   w_next_state;
    logic [N-1:0]   r_pc;
    logic [N-1:0]   w_next_pc;
    logic           w_fetch;
    logic           w_deq;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    fetch_entry_t   w_push_entry;
    fetch_entry_t   w_head;

    assign w_push_entry = '{pc: r_pc, instr: fif.imem_q};
    assign w_deq        = !w_empty && fif.out_ready && !fif.redirect_valid;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_fetch      = 1'b0;
        if (fif.redirect_valid) begin
            w_next_pc = fif.redirect_pc;
            if (!pc_legal(fif.redirect_pc)) begin
                w_next_state = FAULT;
            end else if (fif.en) begin
                w_next_state = RUN;
            end else begin
                w_next_state = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (fif.en) begin
                        w_next_state = RUN;
                    end
                end
                RUN: begin
                    if (!fif.en) begin
                        w_next_state = IDLE;
                    end else if (!pc_legal(r_pc)) begin
                        w_next_state = FAULT;
                    end else if (!w_full || w_deq) begin
                        w_fetch   = 1'b1;
                        w_next_pc = r_pc + N'(PC_STEP);
                    end
                end
                FAULT: begin
                    w_next_state = FAULT;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fetch),
        .i_pop   (w_deq),
        .i_flush (fif.redirect_valid),
        .i_dat   (w_push_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign fif.imem_addr = r_pc[ROM_AW+1:2];
    assign fif.out_valid = (w_count != '0) && (w_count <= DEPTH_CNT);
    assign fif.out_instr = w_head.instr;
    assign fif.out_pc    = w_head.pc;
    assign fif.fault     = (r_state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a modelled 64-word ROM.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_if #(.N(64), .INSTR_W(32)) fif ();

    fetch_unit #(
        .N        (64),
        .INSTR_W  (32),
        .DEPTH    (2),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .fif   (fif)
    );

    logic [31:0] rom [64];
    assign fif.imem_q = rom[fif.imem_addr];

    typedef struct {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        ev;
        logic [63:0] epc;
        logic [31:0] ei;
        logic        ef;
        logic [5:0]  ea;
    } vec_t;

    vec_t vecs [$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic en, input logic rdy, input logic rv,
                       input logic [63:0] rpc, input logic ev, input logic [63:0] epc,
                       input logic [31:0] ei, input logic ef, input logic [5:0] ea);
        vec_t v;
        v.rst = r; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ei = ei; v.ef = ef; v.ea = ea;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [63:0] epc,
                            input logic [31:0] ei, input logic ef, input logic [5:0] ea);
        chk({tag, ".out_valid"}, 64'(fif.out_valid), 64'(ev));
        chk({tag, ".out_pc"},    fif.out_pc,         epc);
        chk({tag, ".out_instr"}, 64'(fif.out_instr), 64'(ei));
        chk({tag, ".fault"},     64'(fif.fault),     64'(ef));
        chk({tag, ".imem_addr"}, 64'(fif.imem_addr), 64'(ea));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | 32'(i);
        rom[0]  = 32'hf800_0001;
        rom[1]  = 32'hf800_8002;
        rom[2]  = 32'hf800_0203;
        rom[46] = 32'hb400_001f;
        rom[47] = 32'h0000_0000;

        fif.en = 1'b0; fif.out_ready = 1'b0;
        fif.redirect_valid = 1'b0; fif.redirect_pc = '0;

        //   rst en rdy rv rpc       ev epc     instr          f  addr
        add(0, 1, 1, 0, 64'h0,    0, 64'h0,  32'h0,         0, 0);
        add(0, 1, 1, 0, 64'h0,    1, 64'h0,  32'hf8000001,  0, 1);
        add(0, 1, 1, 0, 64'h0,    1, 64'h4,  32'hf8008002,  0, 2);
        add(0, 1, 1, 0, 64'h0,    1, 64'h8,  32'hf8000203,  0, 3);
        add(1, 1, 1, 0, 64'h0,    0, 64'h0,  32'h0,         0, 0);
        add(0, 1, 0, 0, 64'h0,    0, 64'h0,  32'h0,         0, 0);
        add(0, 1, 0, 0, 64'h0,    1, 64'h0,  32'hf8000001,  0, 1);
        add(0, 1, 0, 0, 64'h0,    1, 64'h0,  32'hf8000001,  0, 2);
        add(0, 1, 0, 0, 64'h0,    1, 64'h0,  32'hf8000001,  0, 2);
        add(0, 1, 0, 0, 64'h0,    1, 64'h0,  32'hf8000001,  0, 2);
        add(0, 1, 1, 0, 64'h0,    1, 64'h4,  32'hf8008002,  0, 3);
        add(0, 1, 0, 0, 64'h0,    1, 64'h4,  32'hf8008002,  0, 3);
        add(0, 1, 1, 1, 64'hB8,   0, 64'h4,  32'hf8008002,  0, 46);
        add(0, 1, 1, 0, 64'h0,    1, 64'hB8, 32'hb400001f,  0, 47);
        add(0, 1, 1, 0, 64'h0,    1, 64'hBC, 32'h00000000,  0, 48);
        add(0, 1, 1, 1, 64'hF4,   0, 64'hBC, 32'h00000000,  0, 61);
        add(0, 1, 1, 0, 64'h0,    1, 64'hF4, 32'h1000003d,  0, 62);
        add(0, 1, 1, 0, 64'h0,    1, 64'hF8, 32'h1000003e,  0, 63);
        add(0, 1, 1, 0, 64'h0,    1, 64'hFC, 32'h1000003f,  0, 0);
        add(0, 1, 1, 0, 64'h0,    0, 64'hFC, 32'h1000003f,  1, 0);
        add(0, 1, 1, 0, 64'h0,    0, 64'hFC, 32'h1000003f,  1, 0);
        add(0, 1, 1, 1, 64'h0,    0, 64'hFC, 32'h1000003f,  0, 0);
        add(0, 1, 1, 0, 64'h0,    1, 64'h0,  32'hf8000001,  0, 1);
        add(0, 1, 1, 1, 64'h6,    0, 64'h0,  32'hf8000001,  1, 1);
        add(0, 1, 1, 0, 64'h0,    0, 64'h0,  32'hf8000001,  1, 1);
        add(0, 1, 0, 1, 64'h10,   0, 64'h0,  32'hf8000001,  0, 4);
        add(0, 1, 0, 0, 64'h0,    1, 64'h10, 32'h10000004,  0, 5);
        add(0, 1, 0, 0, 64'h0,    1, 64'h10, 32'h10000004,  0, 6);
        add(0, 0, 0, 0, 64'h0,    1, 64'h10, 32'h10000004,  0, 6);
        add(0, 0, 1, 0, 64'h0,    1, 64'h14, 32'h10000005,  0, 6);
        add(0, 0, 1, 0, 64'h0,    0, 64'h14, 32'h10000005,  0, 6);
        add(0, 1, 1, 0, 64'h0,    0, 64'h14, 32'h10000005,  0, 6);
        add(0, 1, 1, 0, 64'h0,    1, 64'h18, 32'h10000006,  0, 7);

        repeat (2) step();
        chk_outs("reset", 0, 64'h0, 32'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst                = vecs[i].rst;
            fif.en             = vecs[i].en;
            fif.out_ready      = vecs[i].rdy;
            fif.redirect_valid = vecs[i].rv;
            fif.redirect_pc    = vecs[i].rpc;
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ei,
                     vecs[i].ef, vecs[i].ea);
        end

        // Asynchronous reset between edges with a live head.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs("async_rst_run", 0, 64'h0, 32'h0, 0, 0);

        // Bounded wait for the first head after leaving reset: two edges after en.
        @(posedge clk);
        #1;
        rst = 1'b0; fif.en = 1'b1; fif.out_ready = 1'b1; fif.redirect_valid = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (fif.out_valid) begin
                cyc = c;
                break;
            end
        end
        chk("first_valid_latency", 64'(cyc), 64'd2);
        chk_outs("first_head", 1, 64'h0, 32'hf8000001, 0, 1);
        step();
        chk_outs("second_head", 1, 64'h4, 32'hf8008002, 0, 2);

        // Misaligned redirect faults, then an async reset clears the trap mid-cycle.
        fif.redirect_valid = 1'b1; fif.redirect_pc = 64'h6;
        step();
        chk_outs("mis_redirect", 0, 64'h4, 32'hf8008002, 1, 1);
        fif.redirect_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk_outs("async_rst_fault", 0, 64'h0, 32'h0, 0, 0);

        step();
        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch controller for the LEGv8 core. It sequences the 64-word combinational instruction ROM (6-bit word address, 32-bit data).
- It owns the PC, drives the ROM address and buffers fetched words in a small prefetch queue.
- It hands {pc, instr} to decode over a valid/ready handshake, accepts branch redirects, and traps misaligned or out-of-range PCs.

Parameters:
N, 64, PC width in bits
INSTR_W, 32, instruction width; matches ROM data width
DEPTH, 2, prefetch queue entries; power of two, at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  fetch enable; low pauses issuing new fetches
imem_addr  out  6  ROM word address, pc[7:2]
imem_q  in  INSTR_W  ROM data, combinational from imem_addr
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  N  redirect target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  N  head PC
fault  out  1  fetch trap active (state FAULT)

Behaviour:
- Reset is asynchronous. Outputs during and after reset:
  - pc=RESET_PC, queue empty, state IDLE.
  - out_valid=0, out_instr=0, out_pc=0, fault=0.
  - imem_addr=RESET_PC[7:2].
- imem_addr is always pc[7:2] and is combinational from the pc register.
- A PC is legal when pc[1:0]==0 and pc[N-1:8]==0.
- FSM states:
  - IDLE: no fetch. Go to RUN when en=1 and no redirect.
  - RUN: fetch = pc legal AND (count<DEPTH OR dequeue this cycle).
    - On fetch: enqueue {pc, imem_q}, then pc<=pc+4.
    - Go to IDLE when en=0.
    - Go to FAULT when pc is illegal. In that case nothing is enqueued and pc holds.
  - FAULT: fault=1 and no fetch. Leaves only on redirect or reset.
- Latency: a word fetched in cycle t appears at the queue head with out_valid=1 in cycle t+1, if the queue was empty. There is no combinational path from imem_q to out_*.
- Dequeue occurs when out_valid && out_ready. Head outputs are registered entries.
- Full queue: the PC holds unless a dequeue occurs in the same cycle. Simultaneous enqueue+dequeue at full is allowed, and count stays DEPTH.
- Empty queue: out_valid=0, and out_instr/out_pc hold their last values.
- Redirect has highest priority, in any state:
  - The queue flushes in the same cycle, and any dequeue in that cycle is suppressed.
  - pc<=redirect_pc; no enqueue that cycle.
  - Next state is FAULT if redirect_pc is illegal; otherwise RUN if en=1, IDLE if en=0.
- PC arithmetic is modulo 2^N. Passing word 63 (pc 0xFC to 0x100) makes pc illegal, which leads to FAULT. The ROM address never silently wraps.
- en=0 with a non-empty queue: draining continues normally.
- Reset mid-operation: all state is cleared immediately and asynchronously; in-flight entries are lost.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_state_e {IDLE, RUN, FAULT}
  - typedef fetch_entry_t {pc, instr}
  - constants PC_STEP=4, ROM_WORDS=64
- Sub-module fetch_queue: a DEPTH-entry synchronous FIFO.
  - Inputs: push, pop, flush.
  - Flags: full, empty, count.
  - flush overrides push and pop.
  - Same clk and reset as the parent.

Test Plan:
- Reset, then en=1 and out_ready=1. The head sequence must start with pc 0x0/0xf8000001, pc 0x4/0xf8008002, pc 0x8/0xf8000203, with out_valid=1 first in the cycle after the first fetch, then one instruction per cycle.
- out_ready=0 for 5 cycles. count must saturate at 2, pc must hold at 0x8, and imem_addr must hold at 2. Raising out_ready must release 0x0 then 0x4 with no loss or duplication.
- redirect_valid=1 with redirect_pc=0xB8 while the queue is full. The queue must flush, and the next head must be pc 0xB8/0xb400001f, followed by pc 0xBC/0x00000000.
- Run to pc 0xFC. The head 0xFC must be delivered, then fault=1 with no further enqueue. A redirect to 0x0 must clear fault and resume at 0xf8000001.
- Redirect to 0x6 (misaligned) must give fault=1 next cycle and out_valid=0. Asserting reset mid-run must immediately clear out_valid, fault and pc to 0.
- en toggled low for 3 cycles mid-stream: no new fetches and pc holds, while queued entries still drain in order.
